// File: rtl/nway_cache_ctrl.sv
// Set-associative write-back / write-allocate cache controller, one word per line.
// Optional hit/miss/write-back counters are built when NWAY_CACHE_STATS_EN is defined.
module nway_cache_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SETS   = 16,
  parameter int WAYS   = 8,
  localparam int SET_W = $clog2(SETS),
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int TAG_W = ADDR_W - SET_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cpu_valid,
  input  logic                   cpu_rw,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  output logic                   cpu_ready,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   cpu_hit,
  output logic [SET_W+WAY_W-1:0] cpu_index,
  output logic                   mem_valid,
  output logic                   mem_rw,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic                   mem_ready,
  input  logic [DATA_W-1:0]      mem_rdata
`ifdef NWAY_CACHE_STATS_EN
  ,
  output logic [31:0]            stat_hits,
  output logic [31:0]            stat_misses,
  output logic [31:0]            stat_wbacks
`endif
);

  // state     | meaning
  // IDLE      | waiting for cpu_valid; lookup runs on the incoming address
  // COMPARE   | cpu_ready visible if the request finished, else pick a victim
  // WRITEBACK | dirty victim being written to memory
  // ALLOCATE  | line being fetched from memory (mem_valid re-raised after a write-back)
  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

  state_t            state;
  logic [WAYS-1:0]   valid    [SETS];
  logic [WAYS-1:0]   dirty    [SETS];
  logic [WAY_W-1:0]  rr_ptr   [SETS];
  logic [TAG_W-1:0]  tag_arr  [SETS][WAYS];
  logic [DATA_W-1:0] data_arr [SETS][WAYS];

  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [DATA_W-1:0] wdata_q;
  logic [WAY_W-1:0]  victim_q;

  logic [SET_W-1:0]  lk_set, set_q;
  logic [TAG_W-1:0]  lk_tag, tag_q;
  logic              lk_hit;
  logic [WAY_W-1:0]  lk_way;
  logic              inv_found;
  logic [WAY_W-1:0]  inv_way, victim, rr_next;
  logic              hit_wr, fill_en;

  assign lk_set = cpu_addr[SET_W-1:0];
  assign lk_tag = cpu_addr[ADDR_W-1:SET_W];
  assign set_q  = addr_q[SET_W-1:0];
  assign tag_q  = addr_q[ADDR_W-1:SET_W];

  // The hit decision is made as the request is accepted so cpu_ready can be registered.
  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[lk_set][w] && tag_arr[lk_set][w] == lk_tag) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[set_q][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    victim  = inv_found ? inv_way : rr_ptr[set_q];
    rr_next = (rr_ptr[set_q] == WAY_W'(WAYS - 1)) ? '0 : rr_ptr[set_q] + WAY_W'(1);
  end

  assign hit_wr  = (state == IDLE) && cpu_valid && lk_hit && cpu_rw;
  assign fill_en = (state == ALLOCATE) && mem_valid && mem_ready;

`ifdef NWAY_CACHE_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      victim_q  <= '0;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      cpu_hit   <= 1'b0;
      cpu_index <= '0;
      mem_valid <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s]  <= '0;
        dirty[s]  <= '0;
        rr_ptr[s] <= '0;
      end
`ifdef NWAY_CACHE_STATS_EN
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_wbacks <= '0;
`endif
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_valid) begin
            addr_q  <= cpu_addr;
            rw_q    <= cpu_rw;
            wdata_q <= cpu_wdata;
            state   <= COMPARE;
            if (lk_hit) begin
              cpu_ready <= 1'b1;
              cpu_hit   <= 1'b1;
              cpu_index <= {lk_set, lk_way};
              cpu_rdata <= cpu_rw ? cpu_wdata : data_arr[lk_set][lk_way];
              if (cpu_rw) dirty[lk_set][lk_way] <= 1'b1;
`ifdef NWAY_CACHE_STATS_EN
              stat_hits <= sat_inc(stat_hits);
`endif
            end
          end
        end
        COMPARE: begin
          if (cpu_ready) begin
            state <= IDLE;
          end else begin
            victim_q <= victim;
            if (!inv_found) rr_ptr[set_q] <= rr_next;
            mem_valid <= 1'b1;
            if (!inv_found && dirty[set_q][victim]) begin
              state     <= WRITEBACK;
              mem_rw    <= 1'b1;
              mem_addr  <= {tag_arr[set_q][victim], set_q};
              mem_wdata <= data_arr[set_q][victim];
            end else begin
              state    <= ALLOCATE;
              mem_rw   <= 1'b0;
              mem_addr <= addr_q;
            end
          end
        end
        WRITEBACK: begin
          if (mem_ready) begin
            mem_valid               <= 1'b0;
            dirty[set_q][victim_q]  <= 1'b0;
            state                   <= ALLOCATE;
`ifdef NWAY_CACHE_STATS_EN
            stat_wbacks <= sat_inc(stat_wbacks);
`endif
          end
        end
        ALLOCATE: begin
          // After a write-back mem_valid was dropped for a cycle; re-raise it for the fetch.
          if (!mem_valid) begin
            mem_valid <= 1'b1;
            mem_rw    <= 1'b0;
            mem_addr  <= addr_q;
          end else if (mem_ready) begin
            mem_valid              <= 1'b0;
            valid[set_q][victim_q] <= 1'b1;
            dirty[set_q][victim_q] <= rw_q;
            cpu_ready              <= 1'b1;
            cpu_hit                <= 1'b0;
            cpu_index              <= {set_q, victim_q};
            cpu_rdata              <= rw_q ? wdata_q : mem_rdata;
            state                  <= COMPARE;
`ifdef NWAY_CACHE_STATS_EN
            stat_misses <= sat_inc(stat_misses);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data storage carry no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (hit_wr) data_arr[lk_set][lk_way] <= cpu_wdata;
    if (fill_en) begin
      tag_arr[set_q][victim_q]  <= tag_q;
      data_arr[set_q][victim_q] <= rw_q ? wdata_q : mem_rdata;
    end
  end

endmodule

// File: tb/tb_nway_cache_ctrl.sv
// Bench for nway_cache_ctrl (SETS=16, WAYS=8): directed table, corner sequences, random vs model.
module tb_nway_cache_ctrl;
  localparam int ADDR_W = 32, DATA_W = 32, SETS = 16, WAYS = 8;

  logic        clk = 0, rst_n = 0;
  logic        cpu_valid = 0, cpu_rw = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0;
  logic        cpu_ready, cpu_hit;
  logic [31:0] cpu_rdata;
  logic [6:0]  cpu_index;
  logic        mem_valid, mem_rw;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready = 0;
  logic [31:0] mem_rdata = 0;
`ifdef NWAY_CACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_wbacks;
`endif

  nway_cache_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETS(SETS), .WAYS(WAYS)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_valid(cpu_valid), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
    .cpu_index(cpu_index), .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
`ifdef NWAY_CACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_wbacks(stat_wbacks)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  // Memory responder: random latency, holds off entirely while mem_hold is set.
  logic [31:0] mem_w [logic [31:0]];
  logic [31:0] wq_a[$], wq_d[$];
  bit mem_hold = 0;
  int mem_wait = 0;
  always @(negedge clk) begin
    if (mem_valid && !mem_hold && (mem_wait >= 3 || $urandom_range(0, 2) == 0)) begin
      mem_ready = 1;
      mem_wait  = 0;
      if (mem_rw) begin
        mem_w[mem_addr] = mem_wdata;
        wq_a.push_back(mem_addr);
        wq_d.push_back(mem_wdata);
      end else begin
        mem_rdata = mem_w.exists(mem_addr) ? mem_w[mem_addr] : mem_init(mem_addr);
      end
    end else begin
      mem_ready = 0;
      if (mem_valid) mem_wait++;
    end
  end

  // Reference model: plain per-set arrays following the replacement rules directly.
  bit          m_valid [SETS][WAYS];
  bit          m_dirty [SETS][WAYS];
  logic [27:0] m_tag   [SETS][WAYS];
  logic [31:0] m_data  [SETS][WAYS];
  int          m_rr    [SETS];
  logic [31:0] ref_mem [logic [31:0]];
  int exp_hits = 0, exp_misses = 0, exp_wbacks = 0;

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
      end
    end
    ref_mem = mem_w;
    exp_hits = 0; exp_misses = 0; exp_wbacks = 0;
  endfunction

  function automatic void mdl(input bit rw, input logic [31:0] a, input logic [31:0] wd,
                              output bit h, output logic [6:0] idx, output logic [31:0] rd,
                              output bit wb, output logic [31:0] wba, output logic [31:0] wbd);
    int s = int'(a[3:0]);
    int way = -1;
    h = 0; wb = 0; wba = 0; wbd = 0;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == a[31:4]) begin h = 1; way = w; end
    if (h) exp_hits++;
    else begin
      exp_misses++;
      for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) way = w;
      if (way < 0) begin
        way = m_rr[s];
        m_rr[s] = (m_rr[s] + 1) % WAYS;
        if (m_dirty[s][way]) begin
          wb = 1; exp_wbacks++;
          wba = {m_tag[s][way], a[3:0]};
          wbd = m_data[s][way];
          ref_mem[wba] = wbd;
        end
      end
      m_valid[s][way] = 1;
      m_dirty[s][way] = 0;
      m_tag[s][way]   = a[31:4];
      m_data[s][way]  = ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
    end
    if (rw) begin m_data[s][way] = wd; m_dirty[s][way] = 1; end
    rd  = m_data[s][way];
    idx = 7'(s * WAYS + way);
  endfunction

  task automatic do_req(input bit rw, input logic [31:0] a, input logic [31:0] wd,
                        output bit hit, output logic [31:0] rd, output logic [6:0] idx,
                        output int lat);
    @(negedge clk);
    cpu_valid = 1; cpu_rw = rw; cpu_addr = a; cpu_wdata = wd;
    @(negedge clk);
    cpu_valid = 0;
    lat = 1;
    while (!cpu_ready && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!cpu_ready) begin
      checks++; errors++;
      $display("FAIL req_timeout: addr %h no cpu_ready after %0d cycles", a, lat);
    end
    hit = cpu_hit; rd = cpu_rdata; idx = cpu_index;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  typedef struct {
    bit rw; logic [31:0] addr; logic [31:0] wdata;
    bit exp_hit; logic [31:0] exp_rdata; logic [6:0] exp_idx;
    bit exp_wb; logic [31:0] exp_wba; logic [31:0] exp_wbd;
  } vec_t;
  vec_t vt[11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit h, wb, eh;
    logic [31:0] rd, wba, wbd, erd, a, wd;
    logic [6:0] idx, eidx;
    int lat, bad;

    vt[0]  = '{0, 32'h13, 32'h0, 0, 32'hDEAD_BEEF, 7'h18, 0, 32'h0, 32'h0};
    vt[1]  = '{0, 32'h13, 32'h0, 1, 32'hDEAD_BEEF, 7'h18, 0, 32'h0, 32'h0};
    vt[2]  = '{1, 32'h13, 32'h1234_5678, 1, 32'h1234_5678, 7'h18, 0, 32'h0, 32'h0};
    for (int i = 0; i < 7; i++) begin
      a = 32'h3 | 32'((i + 2) << 4);
      vt[3 + i] = '{0, a, 32'h0, 0, mem_init(a), 7'(3 * 8 + i + 1), 0, 32'h0, 32'h0};
    end
    vt[10] = '{0, 32'h93, 32'h0, 0, mem_init(32'h93), 7'h18, 1, 32'h13, 32'h1234_5678};
    mem_w[32'h13] = 32'hDEAD_BEEF;

    repeat (3) @(negedge clk);
    chk("rst_cpu_ready", 32'(cpu_ready), 0);
    chk("rst_mem_valid", 32'(mem_valid), 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_cpu_index", 32'(cpu_index), 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst_n = 1;

    for (int i = 0; i < 11; i++) begin
      wq_a.delete(); wq_d.delete();
      do_req(vt[i].rw, vt[i].addr, vt[i].wdata, h, rd, idx, lat);
      chk($sformatf("tbl%0d_hit", i), 32'(h), 32'(vt[i].exp_hit));
      chk($sformatf("tbl%0d_idx", i), 32'(idx), 32'(vt[i].exp_idx));
      if (!vt[i].rw) chk($sformatf("tbl%0d_rdata", i), rd, vt[i].exp_rdata);
      if (vt[i].exp_hit) chk($sformatf("tbl%0d_latency", i), 32'(lat), 1);
      chk($sformatf("tbl%0d_wb_count", i), 32'(wq_a.size()), 32'(vt[i].exp_wb));
      if (vt[i].exp_wb && wq_a.size() > 0) begin
        chk($sformatf("tbl%0d_wb_addr", i), wq_a[0], vt[i].exp_wba);
        chk($sformatf("tbl%0d_wb_data", i), wq_d[0], vt[i].exp_wbd);
      end
    end

    // Memory stalled during ALLOCATE; cpu_valid pulses must be ignored.
    mem_hold = 1;
    @(negedge clk); cpu_valid = 1; cpu_rw = 0; cpu_addr = 32'h04;
    @(negedge clk); cpu_valid = 0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!mem_valid || cpu_ready) bad++;
      cpu_valid = (c % 5 == 2); cpu_rw = 1; cpu_addr = 32'h13; cpu_wdata = 32'hBAD0_BAD0;
    end
    cpu_valid = 0;
    chk("stall_hold_cycles_bad", 32'(bad), 0);
    mem_hold = 0;
    lat = 0;
    while (!cpu_ready && lat < 50) begin @(negedge clk); lat++; end
    chk("stall_ready", 32'(cpu_ready), 1);
    chk("stall_rdata", cpu_rdata, mem_init(32'h04));
    chk("stall_hit", 32'(cpu_hit), 0);
    bad = 0;
    repeat (5) begin @(negedge clk); if (cpu_ready || mem_valid) bad++; end
    chk("stall_pulse_ignored", 32'(bad), 0);
    do_req(0, 32'h13, 0, h, rd, idx, lat);
    chk("stall_no_write_leak", rd, 32'h1234_5678);

    // Round-robin replacement in set 5.
    do_reset();
    wq_a.delete(); wq_d.delete();
    for (int t = 0; t < 8; t++) begin
      do_req(0, 32'((t << 4) | 5), 0, h, rd, idx, lat);
      chk($sformatf("fill5_idx%0d", t), 32'(idx), 32'(5 * 8 + t));
    end
    for (int t = 8; t < 11; t++) begin
      do_req(0, 32'((t << 4) | 5), 0, h, rd, idx, lat);
      chk($sformatf("rr5_idx%0d", t), 32'(idx), 32'(5 * 8 + t - 8));
      chk($sformatf("rr5_hit%0d", t), 32'(h), 0);
    end
    chk("rr5_no_mem_writes", 32'(wq_a.size()), 0);

    // Reset during WRITEBACK: pointer of set 5 is now 3, way 3 holds tag 3.
    do_req(1, 32'h35, 32'hCAFE_F00D, h, rd, idx, lat);
    chk("wb_setup_hit", 32'(h), 1);
    chk("wb_setup_idx", 32'(idx), 32'(5 * 8 + 3));
    mem_hold = 1;
    @(negedge clk); cpu_valid = 1; cpu_rw = 0; cpu_addr = 32'hB5;
    @(negedge clk); cpu_valid = 0;
    lat = 0;
    while (!mem_valid && lat < 10) begin @(negedge clk); lat++; end
    chk("wb_mem_valid", 32'(mem_valid), 1);
    chk("wb_mem_rw", 32'(mem_rw), 1);
    chk("wb_mem_addr", mem_addr, 32'h35);
    chk("wb_mem_wdata", mem_wdata, 32'hCAFE_F00D);
    repeat (2) @(negedge clk);
    #2 rst_n = 0;
    #1 chk("wb_async_drop", 32'(mem_valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    mem_hold = 0;
    model_reset();
    mdl(0, 32'hB5, 0, eh, eidx, erd, wb, wba, wbd);
    do_req(0, 32'hB5, 0, h, rd, idx, lat);
    chk("post_rst_miss", 32'(h), 0);
    chk("post_rst_idx", 32'(idx), 32'(eidx));

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      bit rw;
      rw = 1'($urandom_range(0, 1));
      a  = {28'($urandom_range(0, 11)), 4'($urandom_range(0, 3))};
      wd = $urandom;
      mdl(rw, a, wd, eh, eidx, erd, wb, wba, wbd);
      wq_a.delete(); wq_d.delete();
      do_req(rw, a, wd, h, rd, idx, lat);
      chk($sformatf("rnd%0d_hit", n), 32'(h), 32'(eh));
      chk($sformatf("rnd%0d_idx", n), 32'(idx), 32'(eidx));
      if (!rw) chk($sformatf("rnd%0d_rdata", n), rd, erd);
      chk($sformatf("rnd%0d_wb_count", n), 32'(wq_a.size()), 32'(wb));
      if (wb && wq_a.size() > 0) begin
        chk($sformatf("rnd%0d_wb_addr", n), wq_a[0], wba);
        chk($sformatf("rnd%0d_wb_data", n), wq_d[0], wbd);
      end
    end

`ifdef NWAY_CACHE_STATS_EN
    @(negedge clk);
    chk("stat_hits", stat_hits, 32'(exp_hits));
    chk("stat_misses", stat_misses, 32'(exp_misses));
    chk("stat_wbacks", stat_wbacks, 32'(exp_wbacks));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nway_cache_ctrl.md
Name: nway_cache_ctrl

Overview:
- Parametrised write-back, write-allocate, set-associative cache controller.
- Generalises the fixed 16-set x 8-way / 128-block organisation to configurable SETS, WAYS and DATA_W.
- Adds round-robin replacement with invalid-first victim selection and dirty-line write-back.
- Sits between the CPU request port and the memory port; one line holds one data word.

Parameters:
- ADDR_W, 32, word-address width.
- DATA_W, 32, line/data width.
- SETS, 16, number of sets; power of two, >= 2.
- WAYS, 8, ways per set; power of two, >= 1 (1 = direct-mapped).
- Derived: SET_W = clog2(SETS), WAY_W = max(1, clog2(WAYS)), TAG_W = ADDR_W - SET_W.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_valid  in  1  request valid; sampled only in IDLE.
- cpu_rw  in  1  0 = read, 1 = write.
- cpu_addr  in  ADDR_W  word address; set = addr[SET_W-1:0], tag = addr[ADDR_W-1:SET_W].
- cpu_wdata  in  DATA_W  write data.
- cpu_ready  out  1  one-cycle pulse, request complete.
- cpu_rdata  out  DATA_W  read data, valid while cpu_ready = 1.
- cpu_hit  out  1  with cpu_ready: 1 = original lookup hit.
- cpu_index  out  SET_W+WAY_W  {set, way} of the serviced line, valid with cpu_ready.
- mem_valid  out  1  memory request valid.
- mem_rw  out  1  0 = read, 1 = write.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  write-back data.
- mem_ready  in  1  memory completes the current request; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (async, rst_n = 0):
  - All valid and dirty bits cleared; all per-set round-robin pointers = 0; FSM to IDLE.
  - All outputs 0. Tag and data arrays are not reset.
- FSM states: IDLE, COMPARE, WRITEBACK, ALLOCATE.
- IDLE: on cpu_valid, latch addr/rw/wdata and go to COMPARE. cpu_valid in any other state is ignored.
- COMPARE:
  - Parallel tag compare across all ways of the set.
  - Hit: cpu_ready = 1 this cycle, then IDLE.
    - Read hit: cpu_rdata = line.
    - Write hit: line <= wdata, dirty <= 1.
    - Hit latency: accept in cycle N, cpu_ready in cycle N+1.
  - Miss, victim selection: lowest-index invalid way; if none, the way at the set's round-robin pointer, then the pointer increments modulo WAYS. The pointer does not move when an invalid way is used.
  - Victim dirty -> WRITEBACK; otherwise -> ALLOCATE.
- WRITEBACK:
  - mem_valid = 1, mem_rw = 1, mem_addr = {victim tag, set}, mem_wdata = victim data.
  - Hold until mem_ready, then clear dirty and go to ALLOCATE.
- ALLOCATE:
  - mem_valid = 1, mem_rw = 0, mem_addr = latched address.
  - On mem_ready: line <= mem_rdata, tag written, valid = 1, dirty = 0; return to COMPARE, which now hits.
  - cpu_hit reports the original lookup result, i.e. 0 on any miss path.
- mem_valid drops the cycle after mem_ready. mem_ready may assert in the same cycle mem_valid rises.
- Exactly one hit per set is guaranteed by construction; behaviour with multiple hits is undefined.
- Reset mid-miss aborts the transaction: mem_valid drops immediately and the line stays invalid.

Optional Feature:
- Macro NWAY_CACHE_STATS_EN.
- When defined:
  - Adds outputs stat_hits, stat_misses, stat_wbacks, each 32 bits.
  - Each increments once per completed request / write-back; saturates at 0xFFFF_FFFF.
  - Cleared by reset.
- When undefined: these ports and counters do not exist.

Test Plan (SETS = 16, WAYS = 8):
- Cold read 0x0000_0013 with mem_rdata = 0xDEAD_BEEF -> ALLOCATE, cpu_ready with cpu_rdata = 0xDEAD_BEEF, cpu_hit = 0; repeat read -> cpu_ready after 1 cycle, cpu_hit = 1, cpu_index = {3, 0}.
- Write 0x0000_0013 = 0x1234_5678 (hit) -> dirty set; 8 further distinct-tag reads to set 3 -> first eviction chooses way 0, WRITEBACK with mem_addr = 0x0000_0013, mem_wdata = 0x1234_5678.
- Fill set 5 with 8 clean lines, then 3 more misses -> victims are ways 0, 1, 2 (round-robin); no memory writes.
- mem_ready held 0 for 20 cycles during ALLOCATE -> mem_valid stays 1, no cpu_ready, and cpu_valid pulses are ignored.
- Assert rst_n = 0 mid-WRITEBACK -> mem_valid = 0 asynchronously; after release, the same address misses.
- With NWAY_CACHE_STATS_EN: 4 hits, 2 misses, 1 write-back -> stat_hits = 4, stat_misses = 2, stat_wbacks = 1.
